uart_bus_master: RTL and testbench

- Bus initiator that drives the memory-mapped UART peripheral's register interface: Address/DataIn/Write/Select out, DataOut in.
- Converts a client byte stream (valid/ready) into register write/poll sequences.
- Converts peripheral receive flags into one-cycle rx byte strobes.
- Sits between a processor-less client (test pattern source, bridge logic) and the UART register block, replacing software drivers.

---
 rtl/uart_bus_master_pkg.sv | 44 ++++
 rtl/uart_bus_master.sv | 182 ++++++++++++++++++
 tb/tb_uart_bus_master.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_bus_master_pkg.sv
// Shared definitions for the UART register-bus initiator: register map,
// SETUP/FLAGS bit positions and FSM state encoding.
package uart_bus_master_pkg;

   localparam logic [2:0] REG_SETUP     = 3'd0;
   localparam logic [2:0] REG_FLAGS     = 3'd1;
   localparam logic [2:0] REG_TX_DATA   = 3'd2;
   localparam logic [2:0] REG_RX_DATA   = 3'd3;
   localparam logic [2:0] REG_BYTE_RATE = 3'd4;

   localparam int unsigned SETUP_TX_SEND     = 0;
   localparam int unsigned SETUP_RX_FLAG_CLR = 3;

   localparam int unsigned FLAG_TX_SENT = 0;
   localparam int unsigned FLAG_RX      = 1;
   localparam int unsigned FLAG_PARITY  = 2;

   typedef logic [3:0] state_t;

   localparam state_t ST_INIT       = 4'd0;
   localparam state_t ST_INIT_SETUP = 4'd1;
   localparam state_t ST_IDLE       = 4'd2;
   localparam state_t ST_TX_DATA    = 4'd3;
   localparam state_t ST_TX_GO      = 4'd4;
   localparam state_t ST_TX_BUSY    = 4'd5;
   localparam state_t ST_TX_DONE    = 4'd6;
   localparam state_t ST_TX_CLR     = 4'd7;
   localparam state_t ST_RX_READ    = 4'd8;
   localparam state_t ST_RX_CLR     = 4'd9;
   localparam state_t ST_RX_REL     = 4'd10;
   localparam state_t ST_RX_WAIT    = 4'd11;

   // SETUP image: base bits pass through, FSM owns tx_send and rx_flag_clr.
   function automatic logic [31:0] setup_word(input logic [31:0] base,
                                              input logic tx_send,
                                              input logic rx_clr);
      logic [31:0] w;
      w = base;
      w[SETUP_TX_SEND]     = tx_send;
      w[SETUP_RX_FLAG_CLR] = rx_clr;
      return w;
   endfunction

endpackage

// File: rtl/uart_bus_master.sv
// Bus initiator for the UART register block: turns a client byte stream into
// register write/poll sequences and peripheral rx flags into rx byte strobes.
module uart_bus_master
   import uart_bus_master_pkg::*;
#(
   parameter logic [31:0] BYTE_RATE_INIT = 32'd5208,
   parameter logic [31:0] SETUP_BASE     = 32'h2,
   parameter logic [31:0] TIMEOUT        = 32'd200_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  tx_byte,
   input  logic        tx_valid,
   output logic        tx_ready,
   output logic        tx_err,
   output logic [7:0]  rx_byte,
   output logic        rx_parity_err,
   output logic        rx_valid,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic        bus_write,
   output logic        bus_select,
   input  logic [31:0] bus_rdata
);

   localparam int unsigned      CNT_W    = $clog2(TIMEOUT) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 32'd1);

   state_t           state_q, state_d;
   logic             active_q;
   logic [CNT_W-1:0] cnt_q;
   logic [7:0]       tx_byte_q;
   logic             flag_par_q;
   logic [7:0]       rx_byte_q;
   logic             rx_par_q;
   logic             rx_valid_q;

   logic [2:0]       acc_reg;
   logic [31:0]      acc_wdata;
   logic             acc_write;
   logic             tx_ready_c, tx_err_c, latch_flags;
   logic             rx_flag, tx_sent, cnt_last;
   logic             unused_rdata;

   assign rx_flag      = bus_rdata[FLAG_RX];
   assign tx_sent      = bus_rdata[FLAG_TX_SENT];
   assign cnt_last     = (cnt_q == CNT_LAST);
   assign unused_rdata = ^bus_rdata[31:8];

   // active_q keeps the bus quiet during reset; INIT's write appears on the first cycle after release.
   always_comb begin
      state_d     = state_q;
      acc_reg     = REG_FLAGS;
      acc_wdata   = '0;
      acc_write   = 1'b0;
      tx_ready_c  = 1'b0;
      tx_err_c    = 1'b0;
      latch_flags = 1'b0;
      case (state_q)
         ST_INIT: begin
            acc_reg   = REG_BYTE_RATE;
            acc_wdata = BYTE_RATE_INIT;
            acc_write = 1'b1;
            state_d   = ST_INIT_SETUP;
         end
         ST_INIT_SETUP: begin
            acc_reg   = REG_SETUP;
            acc_wdata = setup_word(SETUP_BASE, 1'b0, 1'b0);
            acc_write = 1'b1;
            state_d   = ST_IDLE;
         end
         ST_IDLE: begin
            if (rx_flag) begin
               latch_flags = 1'b1;
               state_d     = ST_RX_READ;
            end else if (tx_valid) begin
               tx_ready_c = 1'b1;
               state_d    = ST_TX_DATA;
            end
         end
         ST_TX_DATA: begin
            acc_reg   = REG_TX_DATA;
            acc_wdata = {24'd0, tx_byte_q};
            acc_write = 1'b1;
            state_d   = ST_TX_GO;
         end
         ST_TX_GO: begin
            acc_reg   = REG_SETUP;
            acc_wdata = setup_word(SETUP_BASE, 1'b1, 1'b0);
            acc_write = 1'b1;
            state_d   = ST_TX_BUSY;
         end
         ST_TX_BUSY: begin
            if (!tx_sent) state_d = ST_TX_DONE;
            else if (cnt_last) begin
               tx_err_c = 1'b1;
               state_d  = ST_TX_CLR;
            end
         end
         ST_TX_DONE: begin
            if (tx_sent) state_d = ST_TX_CLR;
            else if (cnt_last) begin
               tx_err_c = 1'b1;
               state_d  = ST_TX_CLR;
            end
         end
         ST_TX_CLR: begin
            acc_reg   = REG_SETUP;
            acc_wdata = setup_word(SETUP_BASE, 1'b0, 1'b0);
            acc_write = 1'b1;
            state_d   = ST_IDLE;
         end
         ST_RX_READ: begin
            acc_reg = REG_RX_DATA;
            state_d = ST_RX_CLR;
         end
         ST_RX_CLR: begin
            acc_reg   = REG_SETUP;
            acc_wdata = setup_word(SETUP_BASE, 1'b0, 1'b1);
            acc_write = 1'b1;
            state_d   = ST_RX_REL;
         end
         ST_RX_REL: begin
            acc_reg   = REG_SETUP;
            acc_wdata = setup_word(SETUP_BASE, 1'b0, 1'b0);
            acc_write = 1'b1;
            state_d   = ST_RX_WAIT;
         end
         ST_RX_WAIT: begin
            if (!rx_flag) state_d = ST_IDLE;
         end
         default: state_d = ST_INIT;
      endcase
      if (!active_q) begin
         state_d     = ST_INIT;
         acc_reg     = '0;
         acc_wdata   = '0;
         acc_write   = 1'b0;
         tx_ready_c  = 1'b0;
         tx_err_c    = 1'b0;
         latch_flags = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_INIT;
         active_q   <= 1'b0;
         cnt_q      <= '0;
         tx_byte_q  <= '0;
         flag_par_q <= 1'b0;
         rx_byte_q  <= '0;
         rx_par_q   <= 1'b0;
         rx_valid_q <= 1'b0;
      end else begin
         active_q   <= 1'b1;
         state_q    <= state_d;
         rx_valid_q <= 1'b0;
         if (tx_ready_c) tx_byte_q <= tx_byte;
         if (latch_flags) flag_par_q <= bus_rdata[FLAG_PARITY];
         if (active_q && state_q == ST_RX_READ) begin
            rx_byte_q  <= bus_rdata[7:0];
            rx_par_q   <= flag_par_q;
            rx_valid_q <= 1'b1;
         end
         if (state_q == ST_TX_GO) cnt_q <= '0;
         else if ((state_q == ST_TX_BUSY || state_q == ST_TX_DONE) && cnt_q != '1)
            cnt_q <= cnt_q + 1'b1;
      end
   end

   assign tx_ready      = tx_ready_c;
   assign tx_err        = tx_err_c;
   assign rx_byte       = rx_byte_q;
   assign rx_parity_err = rx_par_q;
   assign rx_valid      = rx_valid_q;
   assign bus_select    = active_q;
   assign bus_addr      = {29'd0, acc_reg};
   assign bus_wdata     = acc_wdata;
   assign bus_write     = acc_write;

endmodule

// File: tb/tb_uart_bus_master.sv
// Bench for uart_bus_master against a behavioural UART register block whose
// transmitter is looped back into its receiver.
module tb_uart_bus_master;

   localparam int FRAME = 12;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [7:0]  tx_byte = 8'd0;
   logic        tx_valid = 1'b0;
   logic        tx_ready, tx_err, rx_parity_err, rx_valid;
   logic [7:0]  rx_byte;
   logic [31:0] bus_addr, bus_wdata, bus_rdata;
   logic        bus_write, bus_select;

   always #5 clk = ~clk;

   uart_bus_master #(.BYTE_RATE_INIT(32'd5208), .SETUP_BASE(32'h2), .TIMEOUT(32'd100)) dut (
      .clk(clk), .rst(rst), .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .tx_err(tx_err), .rx_byte(rx_byte), .rx_parity_err(rx_parity_err), .rx_valid(rx_valid),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_write(bus_write),
      .bus_select(bus_select), .bus_rdata(bus_rdata));

   int total = 0;
   int bad   = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // ---------------- peripheral model ----------------
   logic [31:0] p_setup, p_rate, p_txd;
   logic        p_sent, p_rxf, p_par;
   logic [7:0]  p_rxd;
   int          p_phase, p_dly, p_cnt, inj_done;
   logic [7:0]  serial_q[$];
   bit          stuck = 1'b0;
   int          inj_seq = 0;
   logic [7:0]  inj_byte = 8'd0;
   logic        inj_par = 1'b0;

   always_comb begin
      bus_rdata = '0;
      case (bus_addr)
         32'd0: bus_rdata = p_setup;
         32'd1: bus_rdata = {29'd0, p_par, p_rxf, p_sent};
         32'd2: bus_rdata = p_txd;
         32'd3: bus_rdata = {24'd0, p_rxd};
         32'd4: bus_rdata = p_rate;
         default: bus_rdata = '0;
      endcase
   end

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         p_setup <= '0; p_rate <= '0; p_txd <= '0; p_sent <= 1'b1; p_rxf <= 1'b0;
         p_par <= 1'b0; p_rxd <= '0; p_phase <= 0; p_dly <= 0; p_cnt <= 0; inj_done <= inj_seq;
      end else begin
         if (bus_select && bus_write) begin
            case (bus_addr)
               32'd0: begin
                  if (bus_wdata[0] && !p_setup[0] && !stuck) begin
                     p_phase <= 1;
                     p_dly   <= int'($urandom_range(0, 3));
                  end
                  if (bus_wdata[3]) p_rxf <= 1'b0;
                  p_setup <= bus_wdata;
               end
               32'd2: p_txd <= bus_wdata;
               32'd4: p_rate <= bus_wdata;
               default: ;
            endcase
         end
         if (p_phase == 1) begin
            if (p_dly == 0) begin p_sent <= 1'b0; p_phase <= 2; p_cnt <= FRAME; end
            else p_dly <= p_dly - 1;
         end else if (p_phase == 2) begin
            if (p_cnt == 0) begin
               p_sent <= 1'b1; p_phase <= 0;
               serial_q.push_back(p_txd[7:0]);
               p_rxd <= p_txd[7:0]; p_rxf <= 1'b1; p_par <= 1'b0;
            end else p_cnt <= p_cnt - 1;
         end
         if (inj_seq != inj_done) begin
            p_rxd <= inj_byte; p_rxf <= 1'b1; p_par <= inj_par; inj_done <= inj_seq;
         end
      end
   end

   // ---------------- monitor ----------------
   typedef struct { int cyc; logic [31:0] addr; logic [31:0] data; } wr_t;
   wr_t        wr_log[$];
   logic [7:0] rx_got[$];
   logic       rx_got_par[$];
   int         rx_cyc[$];
   int         err_cyc[$];
   int         rdy_cnt = 0;
   int         cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      #2;
      if (rst) begin
         if (bus_select && bus_write) wr_log.push_back('{cyc, bus_addr, bus_wdata});
         if (rx_valid) begin
            rx_got.push_back(rx_byte); rx_got_par.push_back(rx_parity_err); rx_cyc.push_back(cyc);
         end
         if (tx_err) err_cyc.push_back(cyc);
         if (tx_ready) rdy_cnt++;
      end
   end

   // ---------------- stimulus helpers ----------------
   int hs_cyc = 0;

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b);
      bit done = 1'b0;
      @(negedge clk);
      tx_byte = b; tx_valid = 1'b1;
      for (int i = 0; i < 400 && !done; i++) begin
         #1;
         if (tx_ready) begin
            hs_cyc = cyc; done = 1'b1;
            @(posedge clk); #1;
         end else @(negedge clk);
      end
      tx_valid = 1'b0;
      if (!done) check("tx_handshake", 32'd0, 32'd1);
   endtask

   task automatic inject(input logic [7:0] b, input logic p);
      @(negedge clk);
      inj_byte = b; inj_par = p; inj_seq++;
   endtask

   task automatic wait_rx(input int n, input string nm);
      int k = 0;
      while (rx_got.size() < n && k < 600) begin @(negedge clk); k++; end
      check(nm, rx_got.size(), n);
   endtask

   typedef struct { bit inj; logic [7:0] b; logic par; logic [7:0] exp_b; logic exp_par; } vec_t;
   vec_t vt[6];

   logic [7:0] exp_rx[$];
   logic       exp_par[$];
   logic [7:0] exp_ser[$];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n0, w0, s0, r0, e0, ne, rel_cyc, base_rx, base_ser, k;
      logic [31:0] ea[5];
      logic [31:0] ed[5];
      logic [7:0]  b;
      logic        p;
      bit          inj;

      vt[0] = '{1'b0, 8'hA5, 1'b0, 8'hA5, 1'b0};
      vt[1] = '{1'b1, 8'h3C, 1'b0, 8'h3C, 1'b0};
      vt[2] = '{1'b1, 8'hE7, 1'b1, 8'hE7, 1'b1};
      vt[3] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
      vt[4] = '{1'b0, 8'hFF, 1'b0, 8'hFF, 1'b0};
      vt[5] = '{1'b1, 8'h81, 1'b1, 8'h81, 1'b1};

      // reset state and INIT sequence
      tick(3);
      check("rst_ctrl", 32'({tx_ready, tx_err, rx_valid, rx_parity_err, bus_write, bus_select}), 32'd0);
      check("rst_addr", bus_addr, 32'd0);
      check("rst_rx_byte", 32'(rx_byte), 32'd0);
      @(negedge clk); rst = 1'b1; rel_cyc = cyc;
      tick(5);
      check("init_nwr", wr_log.size(), 2);
      check("init_w0_addr", wr_log[0].addr, 32'd4);
      check("init_w0_data", wr_log[0].data, 32'd5208);
      check("init_w0_cyc", wr_log[0].cyc, rel_cyc + 1);
      check("init_w1_addr", wr_log[1].addr, 32'd0);
      check("init_w1_data", wr_log[1].data, 32'h2);
      check("init_w1_cyc", wr_log[1].cyc, rel_cyc + 2);
      check("idle_poll", 32'({bus_select, bus_write, bus_addr[2:0]}), 32'b10001);
      check("idle_client", 32'({tx_ready, tx_err, rx_valid}), 32'd0);

      // table-driven transactions
      for (int i = 0; i < 6; i++) begin
         n0 = rx_got.size(); w0 = wr_log.size(); s0 = serial_q.size(); r0 = rdy_cnt;
         if (vt[i].inj) inject(vt[i].b, vt[i].par);
         else send_byte(vt[i].b);
         wait_rx(n0 + 1, $sformatf("vec%0d_rx_seen", i));
         tick(30);
         check($sformatf("vec%0d_rx_byte", i), 32'(rx_got[n0]), 32'(vt[i].exp_b));
         check($sformatf("vec%0d_rx_par", i), 32'(rx_got_par[n0]), 32'(vt[i].exp_par));
         check($sformatf("vec%0d_rx_held", i), 32'(rx_byte), 32'(vt[i].exp_b));
         check($sformatf("vec%0d_rx_once", i), rx_got.size(), n0 + 1);
         ne = 0;
         if (!vt[i].inj) begin
            check($sformatf("vec%0d_serial_n", i), serial_q.size(), s0 + 1);
            check($sformatf("vec%0d_serial", i), 32'(serial_q[s0]), 32'(vt[i].b));
            check($sformatf("vec%0d_ready_once", i), rdy_cnt, r0 + 1);
            ea[0] = 32'd2; ed[0] = {24'd0, vt[i].b};
            ea[1] = 32'd0; ed[1] = 32'h3;
            ea[2] = 32'd0; ed[2] = 32'h2;
            ne = 3;
         end
         ea[ne] = 32'd0; ed[ne] = 32'hA; ne++;
         ea[ne] = 32'd0; ed[ne] = 32'h2; ne++;
         check($sformatf("vec%0d_nwr", i), wr_log.size() - w0, ne);
         for (int j = 0; j < ne; j++) begin
            check($sformatf("vec%0d_wr%0d", i, j),
                  {wr_log[w0+j].addr[7:0], wr_log[w0+j].data[23:0]}, {ea[j][7:0], ed[j][23:0]});
         end
      end

      // rx pending and tx offered in the same IDLE cycle: rx wins
      n0 = rx_got.size(); s0 = serial_q.size();
      inject(8'h96, 1'b0);
      send_byte(8'h55);
      wait_rx(n0 + 2, "prio_rx_seen");
      tick(30);
      check("prio_first_rx", 32'(rx_got[n0]), 32'h96);
      check("prio_rx_before_tx", 32'(rx_cyc[n0] < hs_cyc), 32'd1);
      check("prio_loop_rx", 32'(rx_got[n0+1]), 32'h55);
      check("prio_serial", 32'(serial_q[s0]), 32'h55);

      // randomized traffic against the reference queues
      base_rx = rx_got.size(); base_ser = serial_q.size();
      for (int i = 0; i < 16; i++) begin
         inj = bit'($urandom_range(0, 1));
         b = 8'($urandom);
         p = inj ? 1'($urandom_range(0, 1)) : 1'b0;
         exp_rx.push_back(b); exp_par.push_back(p);
         if (inj) inject(b, p);
         else begin exp_ser.push_back(b); send_byte(b); end
         wait_rx(base_rx + i + 1, $sformatf("rnd%0d_seen", i));
         tick(6 + int'($urandom_range(0, 5)));
      end
      for (int i = 0; i < 16; i++) begin
         check($sformatf("rnd%0d_byte", i), 32'(rx_got[base_rx+i]), 32'(exp_rx[i]));
         check($sformatf("rnd%0d_par", i), 32'(rx_got_par[base_rx+i]), 32'(exp_par[i]));
      end
      check("rnd_serial_n", serial_q.size() - base_ser, exp_ser.size());
      for (int i = 0; i < exp_ser.size(); i++)
         check($sformatf("rnd_ser%0d", i), 32'(serial_q[base_ser+i]), 32'(exp_ser[i]));

      // tx_sent stuck high: timeout after 100 cycles
      stuck = 1'b1;
      w0 = wr_log.size(); e0 = err_cyc.size(); s0 = serial_q.size(); n0 = rx_got.size();
      send_byte(8'h77);
      tick(140);
      check("to_nerr", err_cyc.size(), e0 + 1);
      check("to_go", {wr_log[w0+1].addr[7:0], wr_log[w0+1].data[23:0]}, {8'd0, 24'h3});
      check("to_delay", err_cyc[e0] - wr_log[w0+1].cyc, 100);
      check("to_clr", {wr_log[w0+2].addr[7:0], wr_log[w0+2].data[23:0]}, {8'd0, 24'h2});
      check("to_clr_cyc", wr_log[w0+2].cyc, err_cyc[e0] + 1);
      check("to_nwr", wr_log.size(), w0 + 3);
      check("to_idle", 32'({bus_select, bus_write, bus_addr[2:0]}), 32'b10001);
      check("to_no_rx", rx_got.size(), n0);
      stuck = 1'b0;

      // reset asserted while waiting for tx_sent
      n0 = rx_got.size(); e0 = err_cyc.size(); s0 = serial_q.size();
      send_byte(8'hC3);
      k = 0;
      while (p_phase != 2 && k < 50) begin @(negedge clk); k++; end
      check("rst_tx_started", p_phase, 2);
      tick(3);
      #1 rst = 1'b0;
      #1;
      check("rstmid_ctrl", 32'({tx_ready, tx_err, rx_valid, rx_parity_err, bus_write, bus_select}), 32'd0);
      check("rstmid_addr", bus_addr, 32'd0);
      check("rstmid_rx_byte", 32'(rx_byte), 32'd0);
      tick(2);
      @(negedge clk); rst = 1'b1; rel_cyc = cyc; w0 = wr_log.size();
      tick(60);
      check("reinit_w0", {wr_log[w0].addr[7:0], wr_log[w0].data[23:0]}, {8'd4, 24'd5208});
      check("reinit_w0_cyc", wr_log[w0].cyc, rel_cyc + 1);
      check("reinit_w1", {wr_log[w0+1].addr[7:0], wr_log[w0+1].data[23:0]}, {8'd0, 24'h2});
      check("reinit_nwr", wr_log.size(), w0 + 2);
      check("reinit_no_err", err_cyc.size(), e0);
      check("reinit_no_rx", rx_got.size(), n0);
      check("reinit_no_serial", serial_q.size(), s0);

      send_byte(8'h5A);
      wait_rx(n0 + 1, "post_rst_rx_seen");
      check("post_rst_rx", 32'(rx_got[n0]), 32'h5A);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
